burst_rr_arbiter: RTL and testbench
===================================

// Module: burst_rr_arbiter
// PURPOSE
//  Round-robin arbiter with bounded bursts, built to share one memory port
//  (read or write side) between REQUESTERS masters.
//  - A winner holds its grant for up to MAX_BURST accepted transfers, then
//    must release it.
//  - The grant is registered and passes to the next master with no idle
//    cycle. Starvation-free: every active requester is served within
//    (REQUESTERS-1)*MAX_BURST transfers.
// PARAMETERS
//  REQUESTERS  3  number of masters, >=2
//  MAX_BURST   4  max accepted transfers per grant, >=1 (1 = plain RR)
//  ID_W        $clog2(REQUESTERS)  localparam, width of grant_id
//  CNT_W       $clog2(MAX_BURST)+1 localparam, width of burst counter
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           reset, asynchronous assert, active-low
//  req          in   REQUESTERS  request per master, level, held while pending
//  ready        in   1           shared resource accepts a transfer this cycle
//  grant        out  REQUESTERS  registered one-hot grant, all-zero when idle
//  grant_valid  out  1           |grant
//  grant_id     out  ID_W        index of granted master (0 when idle)
//  xfer         out  1           grant_valid & req[grant_id] & ready (comb)
//  burst_last   out  1           xfer and it is the MAX_BURST-th of the grant
// BEHAVIOUR
//  Reset (rst_n=0, async): grant=0, grant_valid=0, grant_id=0, cnt=0,
//   state=IDLE, last-winner pointer=REQUESTERS-1 (master 0 wins first).
//   A reset mid-burst drops grant immediately; the burst is not resumed.
//  Priority: search starts at (ptr+1) mod REQUESTERS and wraps; ptr = last winner.
//  FSM IDLE:
//   - |req=0: stay.
//   - Else: at the next edge, grant goes one-hot to the winner, ptr=winner,
//     cnt=0, state=BUSY.
//   - Grant latency from req rise: 1 cycle.
//  FSM BUSY, owner o:
//   - xfer=1: cnt<=cnt+1.
//   - ready=0: cnt and grant frozen (stall).
//   - Release condition, R = !req[o] | burst_last.
//   - If R and |req_next: re-arbitrate in the same cycle and load the new
//     one-hot grant at the edge. req_next = req with bit o masked when
//     burst_last. If that leaves no request but req[o]=1, regrant o.
//     Result: grant is continuous, no bubble; cnt<=0.
//   - If R and no eligible req: grant<=0, state=IDLE.
//   - If req[o] drops without xfer, the grant still releases at the next edge.
//     The one cycle of grant with req[o]=0 is harmless (xfer=0).
//  Width rules:
//   - cnt counts 0..MAX_BURST-1.
//   - burst_last = xfer & (cnt==MAX_BURST-1), so it never wraps.
//   - With MAX_BURST=1, every xfer is burst_last.
//  Simultaneous events:
//   - New req arriving while BUSY waits; it never pre-empts the owner.
//   - Owner dropping req on its burst_last cycle gives a single release,
//     not double.
//  Invariants (assert):
//   - $onehot0(grant).
//   - grant_valid==|grant.
//   - grant changes only at release or reset.
//   - burst_last implies xfer.
// TESTING (REQUESTERS=3, MAX_BURST=4)
//  1 rst_n=0 mid-stream -> grant=000, grant_valid=0, grant_id=0 at once.
//    After release, req=111 -> grant=001 first.
//  2 req=010 held, ready=1 -> grant=010 after 1 cycle.
//    burst_last on 4th xfer, then regrant 010 with no gap; cnt restarts at 0.
//  3 req=111, ready=1 -> grant 001x4, 010x4, 100x4, 001... with no idle
//    cycles; burst_last every 4th cycle.
//  4 req=111, ready toggles 1,0,0,1,1,1 -> grant 001 held for all 6 cycles.
//    burst_last on the 6th cycle (4th xfer).
//  5 Owner 0 drops req after 2 xfers with req[2]=1 -> next cycle grant=100.
//    Cnt=0 and master 1 is skipped (not requesting).
//  6 MAX_BURST=1 build, req=101, ready=1 -> grant alternates 001,100 every
//    cycle.

Source files
------------

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter
//   Round-robin arbiter with bounded bursts. It shares one memory port
//   between REQUESTERS masters. A winner keeps its registered one-hot grant
//   for up to MAX_BURST accepted transfers, and then it must let go. The
//   grant passes straight to the next master with no idle cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        async active-low reset
//   req          per-master level request, held while pending
//   ready        shared resource accepts a transfer this cycle
//   grant        registered one-hot grant, zero when idle
//   grant_valid  |grant
//   grant_id     index of granted master (0 when idle)
//   xfer         accepted transfer this cycle (comb)
//   burst_last   xfer that is the MAX_BURST-th of the current grant
module burst_rr_arbiter #(
  parameter  int REQUESTERS = 3,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(REQUESTERS),
  localparam int CNT_W      = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQUESTERS-1:0] req,
  input  logic                  ready,
  output logic [REQUESTERS-1:0] grant,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic                  xfer,
  output logic                  burst_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [ID_W-1:0]       LAST_ID  = ID_W'(REQUESTERS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [REQUESTERS-1:0] ONE_HOT0 = REQUESTERS'(1);

  logic [0:0]            state;
  logic [ID_W-1:0]       ptr;       // last winner; search starts one past it
  logic [CNT_W-1:0]      cnt;       // accepted transfers in the current grant
  logic [REQUESTERS-1:0] req_elig;  // requests allowed to win this cycle
  logic [ID_W-1:0]       win;
  logic                  any_elig;
  logic                  rel;
  logic                  load;

  assign grant_valid = |grant;
  assign xfer        = grant_valid & req[grant_id] & ready;
  assign burst_last  = xfer & (cnt == CNT_LAST);

  // The owner releases when it stops requesting or when it finishes its burst.
  assign rel = (state == S_BUSY) & (~req[grant_id] | burst_last);

  // A master that has finished its burst steps aside. If nobody else wants
  // the port, it is granted again so the port does not idle.
  always_comb begin
    req_elig = req;
    if (burst_last) begin
      req_elig[grant_id] = 1'b0;
      if (req_elig == '0) req_elig[grant_id] = 1'b1;
    end
  end

  // Rotating priority search. The loop runs from the farthest candidate to
  // the nearest, so the last hit is the one closest after ptr.
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    for (int i = REQUESTERS; i >= 1; i--) begin
      if (req_elig[ID_W'((int'(ptr) + i) % REQUESTERS)]) begin
        win      = ID_W'((int'(ptr) + i) % REQUESTERS);
        any_elig = 1'b1;
      end
    end
  end

  assign load = ((state == S_IDLE) & (|req)) | (rel & any_elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= LAST_ID;
      cnt      <= '0;
    end else if (load) begin
      state    <= S_BUSY;
      grant    <= ONE_HOT0 << win;
      grant_id <= win;
      ptr      <= win;
      cnt      <= '0;
    end else if (rel) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else if (xfer) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                             (!load && !rel) |=> $stable(grant));
  a_last:   assert property (@(posedge clk) disable iff (!rst_n) burst_last |-> xfer);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter. It drives a REQUESTERS=3,
// MAX_BURST=4 instance and a MAX_BURST=1 instance from the same inputs.
// Inputs change on the falling edge and outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_burst_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic       ready;

  logic [2:0] grant, grant_b;
  logic       grant_valid, grant_valid_b;
  logic [1:0] grant_id, grant_id_b;
  logic       xfer, xfer_b;
  logic       burst_last, burst_last_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  burst_rr_arbiter #(.REQUESTERS(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .xfer(xfer), .burst_last(burst_last)
  );

  burst_rr_arbiter #(.REQUESTERS(3), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .grant(grant_b), .grant_valid(grant_valid_b), .grant_id(grant_id_b),
    .xfer(xfer_b), .burst_last(burst_last_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [2:0] r, input logic rd);
    @(negedge clk);
    req   = r;
    ready = rd;
    #1;
  endtask

  logic rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    ready = 1'b0;
    #1;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst gv",    32'(grant_valid), 32'h0);
    chk("rst gid",   32'(grant_id), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset mid-burst drops the grant at once
    drv(3'b010, 1'b1);
    chk("t1 latency", 32'(grant), 32'h0);
    drv(3'b010, 1'b1);
    chk("t1 grant", 32'(grant), 32'b010);
    chk("t1 xfer",  32'(xfer), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1 async grant", 32'(grant), 32'h0);
    chk("t1 async gv",    32'(grant_valid), 32'h0);
    chk("t1 async gid",   32'(grant_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b111;
    ready = 1'b1;
    #1;
    chk("t1 idle", 32'(grant), 32'h0);

    // full rotation, 4 transfers each, no gaps
    for (int k = 0; k < 12; k++) begin
      drv(3'b111, 1'b1);
      chk($sformatf("t3 grant k%0d", k), 32'(grant), 32'(3'b001 << (k / 4)));
      chk($sformatf("t3 gid k%0d", k), 32'(grant_id), 32'(k / 4));
      chk($sformatf("t3 last k%0d", k), 32'(burst_last), 32'((k % 4) == 3));
    end

    // ready stalls freeze the burst
    for (int k = 0; k < 6; k++) begin
      drv(3'b111, rdy_pat[k]);
      chk($sformatf("t4 grant k%0d", k), 32'(grant), 32'b001);
      chk($sformatf("t4 xfer k%0d", k), 32'(xfer), 32'(rdy_pat[k]));
      chk($sformatf("t4 last k%0d", k), 32'(burst_last), 32'(k == 5));
    end

    // owner 1 drops its request immediately, so the grant moves to master 0
    drv(3'b001, 1'b1);
    chk("t5 pre grant", 32'(grant), 32'b010);
    chk("t5 pre xfer",  32'(xfer), 32'h0);
    drv(3'b101, 1'b1);
    chk("t5 own0 a", 32'(grant), 32'b001);
    chk("t5 xfer a", 32'(xfer), 32'h1);
    drv(3'b101, 1'b1);
    chk("t5 own0 b", 32'(grant), 32'b001);
    chk("t5 xfer b", 32'(xfer), 32'h1);
    // owner 0 drops after 2 transfers; master 1 is idle, master 2 is next
    drv(3'b100, 1'b1);
    chk("t5 drop grant", 32'(grant), 32'b001);
    chk("t5 drop xfer",  32'(xfer), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drv(3'b100, 1'b1);
      chk($sformatf("t5 grant2 k%0d", k), 32'(grant), 32'b100);
      chk($sformatf("t5 gid2 k%0d", k), 32'(grant_id), 32'h2);
      chk($sformatf("t5 last k%0d", k), 32'(burst_last), 32'(k == 3));
    end
    drv(3'b100, 1'b1);
    chk("t5 regrant", 32'(grant), 32'b100);
    chk("t5 regrant last", 32'(burst_last), 32'h0);
    drv(3'b000, 1'b1);
    chk("t5 rel grant", 32'(grant), 32'b100);
    chk("t5 rel xfer",  32'(xfer), 32'h0);
    drv(3'b000, 1'b1);
    chk("t5 idle grant", 32'(grant), 32'h0);
    chk("t5 idle gv",    32'(grant_valid), 32'h0);
    chk("t5 idle gid",   32'(grant_id), 32'h0);

    // single requester: burst, then regrant with no gap
    drv(3'b010, 1'b1);
    chk("t2 latency", 32'(grant), 32'h0);
    for (int k = 0; k < 8; k++) begin
      drv(3'b010, 1'b1);
      chk($sformatf("t2 grant k%0d", k), 32'(grant), 32'b010);
      chk($sformatf("t2 last k%0d", k), 32'(burst_last), 32'((k % 4) == 3));
    end

    // MAX_BURST=1 instance alternates every cycle
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    drv(3'b101, 1'b1);
    chk("t6 latency", 32'(grant_b), 32'h0);
    for (int k = 0; k < 6; k++) begin
      drv(3'b101, 1'b1);
      chk($sformatf("t6 grant_b k%0d", k), 32'(grant_b), ((k % 2) == 0) ? 32'b001 : 32'b100);
      chk($sformatf("t6 last_b k%0d", k), 32'(burst_last_b), 32'h1);
      chk($sformatf("t6 grant k%0d", k), 32'(grant), (k < 4) ? 32'b001 : 32'b100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
